apb_multi_slv: RTL
==================

# apb_multi_slv

Parametrised, synthesizable APB slave model that replaces the port-only DUT stub in the APB UVC example bench. It implements SLV_NUM independent register banks, one per `psel` bit, with programmable wait states, byte strobes and `pslverr` generation. The APB UVC master agent drives it directly, and the bench's scoreboard checks against its contents.

## Interface
- ADDR_WIDTH, 32: `paddr` width.
- DATA_WIDTH, 32: `pwdata`/`prdata` width; a multiple of 8, range 8–64.
- SLV_NUM, 15: number of `psel` lines, which is also the number of banks.
- REG_DEPTH, 16: words per bank; a power of two, at least 2.
- WAIT_CYCLES, 2: wait states inserted per transfer, range 0–15; honoured only with APB_SLV_WAIT_EN.

Ports (clock and reset first):
- pclk  in  1  APB clock; all logic is clocked on its rising edge.
- presetn  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  SLV_NUM  slave selects, expected one-hot.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- pready  out  1  transfer completion.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  transfer error.

## Operation
- **Storage:** SLV_NUM×REG_DEPTH words of flops.
- **Decode:**
  - Bank = index of the set `psel` bit.
  - Word = `paddr[$clog2(REG_DEPTH)+1:2]`.
- **Error conditions**, evaluated at setup:
  - `paddr[1:0]` ≠ 0;
  - any `paddr` bit at or above `$clog2(REG_DEPTH)+2` is set;
  - `psel` has more than one bit set.
- **FSM states:** IDLE, WAIT, ACCESS. State encoding lives in the package.
- **IDLE:**
  - If any `psel` bit is set and `penable`=0 (setup phase), latch address, direction, data, strobe and error flag.
  - Load wait counter = WAIT_CYCLES.
  - Go to WAIT if the counter is nonzero, otherwise to ACCESS.
- **WAIT:**
  - Decrement the counter each cycle.
  - Go to ACCESS when it reaches 1.
- **ACCESS:**
  - `pready`=1 for exactly one cycle.
  - Always return to IDLE.
- **Write commit:** at the rising edge that ends the ACCESS cycle, only when no error.
  - Each byte lane is updated only where `pstrb` is 1.
  - `pstrb`=0 completes with no change and no error.
- **Read data:**
  - `prdata` is registered and valid only in the ACCESS cycle; it is 0 otherwise.
  - `prdata` = 0 on error.
- **`pslverr`:** equals the latched error flag during ACCESS; 0 otherwise.
- **Abort:** if every `psel` bit drops in WAIT, return to IDLE.
  - No write takes place.
  - `pready` is never asserted for that transfer.
- **Ignored:** `penable` without a prior setup (IDLE, `penable`=1) gets no response.
- **Reset** (asynchronous assert, synchronous deassert by the bench):
  - State returns to IDLE.
  - `pready`=0, `prdata`=0, `pslverr`=0.
  - All bank words are cleared to 0.
  - An in-flight write is dropped.

## Timing
- Setup in cycle T.
- With WAIT_CYCLES=N, `pready` is high in cycle T+1+N, so there are N wait states.
- N=0 gives a zero-wait transfer: `pready` is high in the first `penable` cycle.
- Back-to-back transfers are supported: a new setup in the cycle after ACCESS is accepted.
- Minimum transfer period is 2+N cycles.
- A read after a write to the same word returns the new value.
- Latched inputs are sampled only at the setup edge; changes to `paddr`/`pwdata` in WAIT are ignored.

## Configuration
- **APB_SLV_WAIT_EN defined:**
  - The wait counter and WAIT state are synthesized.
  - WAIT_CYCLES is honoured.
- **APB_SLV_WAIT_EN undefined:**
  - No counter and no WAIT state.
  - WAIT_CYCLES is ignored.
  - Every transfer is zero-wait.

## Structure
- **Package `apb_slv_pkg`:**
  - FSM state enum;
  - `APB_ALIGN_BITS` = 2;
  - error-reason enum (MISALIGN, RANGE, MULTISEL), used for coverage.
- **Sub-module `apb_slv_regbank`:**
  - One REG_DEPTH×DATA_WIDTH bank with byte-strobe write and asynchronous clear.
  - Generated SLV_NUM times.
  - The top module holds decode, the FSM and the output registers.

## Test plan
- Write `0xDEADBEEF` with `pstrb`=`4'hF`, `psel`=bit 3, `paddr`=`0x8`; then read the same address. Read must return `0xDEADBEEF` with `pslverr`=0, and bank 2 at `0x8` must read 0.
- Partial write `pwdata`=`0x11223344`, `pstrb`=`4'b0101` over stored `0xDEADBEEF`. A later read must return `0xDE22BE44`.
- Errors: `paddr`=`0x2` (misaligned), `paddr`=`0x40` with REG_DEPTH=16 (range), `psel`=`0x3` (multi-select). Each must give `pready`=1 and `pslverr`=1; reads return 0 and storage is unchanged.
- Wait states: with APB_SLV_WAIT_EN and WAIT_CYCLES=2, `pready` rises exactly 3 cycles after setup. Without the macro it rises exactly 1 cycle after setup.
- Abort and reset:
  - Drop `psel` during WAIT on a write of `0x5A5A5A5A`: no `pready`, and the word is unchanged.
  - Assert `presetn`=0 mid-WAIT: outputs go to 0 immediately, and all words read 0 afterwards.
- Back-to-back: 16 consecutive alternating write/read transfers to banks 0…14 with zero gap. Each must complete in 2+N cycles with matching read data.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared types for the APB multi-bank slave model: FSM state encoding,
// address alignment and the error-reason classification.
package apb_slv_pkg;

    // Byte address bits below the word index.
    localparam int APB_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Reason a transfer was flagged; ERR_NONE means the transfer is legal.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_MULTISEL = 2'd3
    } apb_err_e;

endpackage

// File: rtl/apb_slv_regbank.sv
// One REG_DEPTH x DATA_WIDTH register bank with byte-strobe write,
// asynchronous clear and a combinational read port.
module apb_slv_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_DEPTH  = 16
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          we,
    input  logic [$clog2(REG_DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic [$clog2(REG_DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [REG_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [REG_DEPTH];

    // Merge the strobed byte lanes of the write into the addressed word.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    // Storage flops, cleared as a whole on reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_multi_slv.sv
// APB slave model with SLV_NUM independent register banks, one per psel bit.
// Optional wait states are built only when APB_SLV_WAIT_EN is defined;
// otherwise every transfer completes with zero wait states.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a setup phase (psel set, penable low)
//   ST_WAIT   | counting wait states; dropping all psel aborts the transfer
//   ST_ACCESS | pready high for one cycle; a legal write commits at its end
module apb_multi_slv #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLV_NUM     = 15,
    parameter int REG_DEPTH   = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [SLV_NUM-1:0]        psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr
);

    import apb_slv_pkg::*;

    localparam int IDX_W     = $clog2(REG_DEPTH);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BANK_W    = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam int RANGE_LSB = IDX_W + APB_ALIGN_BITS;

    // Reject parameter sets the decode cannot represent.
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_dw
        $error("apb_multi_slv: DATA_WIDTH must be a multiple of 8 in 8..64");
    end
    if (REG_DEPTH < 2 || (1 << IDX_W) != REG_DEPTH) begin : g_bad_depth
        $error("apb_multi_slv: REG_DEPTH must be a power of two >= 2");
    end
    if (ADDR_WIDTH <= RANGE_LSB) begin : g_bad_aw
        $error("apb_multi_slv: ADDR_WIDTH too small for REG_DEPTH");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_multi_slv: WAIT_CYCLES must be in 0..15");
    end

    apb_state_e            state_q, state_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [IDX_W-1:0]      word_q, word_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    apb_err_e              err_q, err_d;

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic                  setup;
    logic [BANK_W-1:0]     bank_live;
    logic [IDX_W-1:0]      word_live;
    apb_err_e              err_live;
    logic                  go_access;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] bank_rdata [SLV_NUM];

    assign setup     = (|psel) && !penable;
    assign word_live = paddr[RANGE_LSB-1:APB_ALIGN_BITS];

    // Bank index is the lowest set psel bit; multi-select is flagged as an error anyway.
    always_comb begin
        bank_live = '0;
        for (int i = SLV_NUM - 1; i >= 0; i--) begin
            if (psel[i]) begin
                bank_live = BANK_W'(i);
            end
        end
    end

    // Classify the setup-phase address/select into an error reason.
    always_comb begin
        err_live = ERR_NONE;
        if (paddr[APB_ALIGN_BITS-1:0] != '0) begin
            err_live = ERR_MISALIGN;
        end else if (|paddr[ADDR_WIDTH-1:RANGE_LSB]) begin
            err_live = ERR_RANGE;
        end else if ($countones(psel) > 1) begin
            err_live = ERR_MULTISEL;
        end
    end

    // Transfer attributes are captured only at the setup edge and held afterwards.
    always_comb begin
        bank_d  = bank_q;
        word_d  = word_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        err_d   = err_q;
        if (state_q == ST_IDLE && setup) begin
            bank_d  = bank_live;
            word_d  = word_live;
            write_d = pwrite;
            wdata_d = pwdata;
            wstrb_d = pstrb;
            err_d   = err_live;
        end
    end

    // Read mux across banks, addressed by the transfer being set up or in flight.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (bank_d == BANK_W'(i)) begin
                rd_data = bank_rdata[i];
            end
        end
    end

    // Next-state and registered-output logic; outputs are loaded on the edge entering ACCESS.
    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        go_access = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
`ifdef APB_SLV_WAIT_EN
                    cnt_d = WAIT_LOAD;
                    if (WAIT_LOAD != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        go_access = 1'b1;
                    end
`else
                    go_access = 1'b1;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            ST_WAIT: begin
                if (!(|psel)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    go_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_ACCESS: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (go_access) begin
            state_d   = ST_ACCESS;
            pready_d  = 1'b1;
            pslverr_d = (err_d != ERR_NONE);
            prdata_d  = (!write_d && err_d == ERR_NONE) ? rd_data : '0;
        end
    end

    // A legal write lands in storage on the edge that ends the ACCESS cycle.
    assign commit = (state_q == ST_ACCESS) && write_q && (err_q == ERR_NONE);

    for (genvar g = 0; g < SLV_NUM; g++) begin : g_bank
        apb_slv_regbank #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_DEPTH  (REG_DEPTH)
        ) u_bank (
            .pclk    (pclk),
            .presetn (presetn),
            .we      (commit && (bank_q == BANK_W'(g))),
            .waddr   (word_q),
            .wdata   (wdata_q),
            .wstrb   (wstrb_q),
            .raddr   (word_d),
            .rdata   (bank_rdata[g])
        );
    end

    // State, latched transfer and output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            bank_q    <= '0;
            word_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            err_q     <= ERR_NONE;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            bank_q    <= bank_d;
            word_q    <= word_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            err_q     <= err_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule
